// File: rtl/pwm_duty_meter_if.sv
// rtl/pwm_duty_meter_if.sv - PWM input and duty/period measurement result bundle
interface pwm_duty_meter_if #(
    parameter int CNT_W = 20
);
    logic             pwm_in;
    logic [7:0]       duty;
    logic             duty_valid;
    logic [CNT_W-1:0] period;
    logic             stuck;
    logic             overrun;

    modport master (
        output pwm_in,
        input  duty, duty_valid, period, stuck, overrun
    );

    modport slave (
        input  pwm_in,
        output duty, duty_valid, period, stuck, overrun
    );
endinterface

// File: rtl/pwm_duty_meter.sv
// rtl/pwm_duty_meter.sv - PWM duty cycle meter: 8-bit brightness code, period and stuck detect
module pwm_duty_meter #(
    parameter int CNT_W       = 20,
    parameter int TIMEOUT     = 800_000,
    parameter int SYNC_STAGES = 2,
    parameter int ACTIVE_LOW  = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    pwm_duty_meter_if.slave  bus
);
    typedef enum logic [0:0] {IDLE, MEASURE} state_t;

    localparam logic             PIN_IDLE = (ACTIVE_LOW != 0);
    localparam logic [CNT_W-1:0] TMO      = CNT_W'(TIMEOUT);

    state_t           state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic             pwm_s;
    logic             pwm_s_d;
    logic             rise;
    logic             tmo;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] per_lat;
    logic [CNT_W:0]   rem;
    logic [7:0]       quo;
    logic [3:0]       div_cnt;
    logic             div_busy;
    logic [7:0]       duty_q;
    logic             duty_valid_q;
    logic [CNT_W-1:0] period_q;
    logic             stuck_q;
    logic             overrun_q;

    logic [CNT_W:0]   trial;
    logic             ge;
    logic [CNT_W:0]   rem_nx;
    logic [8:0]       quo_nx;
    logic [7:0]       duty_sat;

    // Sync chain resets to the pin's inactive level so reset release never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{PIN_IDLE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pwm_in};
        end
    end

    assign pwm_s = sync_q[SYNC_STAGES-1] ^ PIN_IDLE;
    assign rise  = pwm_s & ~pwm_s_d;
    assign tmo   = (per_cnt == TMO) && !rise;

    // Restoring divide of hi*256 by period: the first step compares hi directly, later steps shift.
    always_comb begin
        trial    = (div_cnt == 4'd0) ? rem : {rem[CNT_W-1:0], 1'b0};
        ge       = (trial >= {1'b0, per_lat});
        rem_nx   = ge ? (trial - {1'b0, per_lat}) : trial;
        quo_nx   = {quo, ge};
        duty_sat = quo_nx[8] ? 8'hFF : quo_nx[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pwm_s_d      <= 1'b0;
            per_cnt      <= '0;
            hi_cnt       <= '0;
            per_lat      <= '0;
            rem          <= '0;
            quo          <= '0;
            div_cnt      <= '0;
            div_busy     <= 1'b0;
            duty_q       <= '0;
            duty_valid_q <= 1'b0;
            period_q     <= '0;
            stuck_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            pwm_s_d      <= pwm_s;
            duty_valid_q <= 1'b0;
            overrun_q    <= 1'b0;

            if (rise) begin
                per_cnt <= CNT_W'(1);
                hi_cnt  <= CNT_W'(1);
            end else if (tmo) begin
                per_cnt <= '0;
                hi_cnt  <= '0;
            end else begin
                per_cnt <= per_cnt + CNT_W'(1);
                hi_cnt  <= hi_cnt + CNT_W'(pwm_s);
            end

            case (state)
                IDLE: begin
                    if (rise) state <= MEASURE;
                end
                MEASURE: begin
                    if (rise) begin
                        if (!div_busy) begin
                            per_lat  <= per_cnt;
                            rem      <= {1'b0, hi_cnt};
                            quo      <= '0;
                            div_cnt  <= '0;
                            div_busy <= 1'b1;
                        end else begin
                            overrun_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (tmo) begin
                state        <= IDLE;
                duty_q       <= pwm_s ? 8'hFF : 8'h00;
                period_q     <= '0;
                stuck_q      <= 1'b1;
                duty_valid_q <= 1'b1;
            end

            if (div_busy) begin
                rem     <= rem_nx;
                quo     <= quo_nx[7:0];
                div_cnt <= div_cnt + 4'd1;
                if (div_cnt == 4'd8) begin
                    div_busy     <= 1'b0;
                    duty_q       <= duty_sat;
                    period_q     <= per_lat;
                    stuck_q      <= 1'b0;
                    duty_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.duty       = duty_q;
    assign bus.duty_valid = duty_valid_q;
    assign bus.period     = period_q;
    assign bus.stuck      = stuck_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_pwm_duty_meter.sv
// tb/tb_pwm_duty_meter.sv - directed bench for pwm_duty_meter (active-high and active-low instances)
module tb_pwm_duty_meter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pwm = 1'b0;
    logic nxt;
    int   cyc = 0;

    int   n_tests = 0;
    int   n_fail = 0;

    bit   gen_on = 1'b0;
    bit   gen_level = 1'b0;
    int   gen_per = 256;
    int   gen_hi = 0;
    int   gen_seq = 0;
    int   g_cnt = 0;
    int   g_seq = 0;
    int   rise_cyc = 0;
    int   start_cyc = 0;

    int   val_total = 0;
    int   bad_total = 0;
    int   ovr_total = 0;
    int   consec = 0;
    logic prev_dv = 1'b0;

    pwm_duty_meter_if #(.CNT_W(20)) bus_a ();
    pwm_duty_meter_if #(.CNT_W(20)) bus_b ();

    assign bus_a.pwm_in = pwm;
    assign bus_b.pwm_in = pwm;

    pwm_duty_meter #(.CNT_W(20), .TIMEOUT(4096), .SYNC_STAGES(2), .ACTIVE_LOW(0)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a.slave)
    );

    pwm_duty_meter #(.CNT_W(20), .TIMEOUT(4096), .SYNC_STAGES(2), .ACTIVE_LOW(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b.slave)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // PWM source: restarts its phase whenever the main sequence reprograms it.
    initial forever begin
        @(posedge clk);
        #1;
        if (g_seq != gen_seq) begin
            g_seq     = gen_seq;
            g_cnt     = 0;
            start_cyc = cyc;
        end
        nxt = gen_on ? (g_cnt < gen_hi) : gen_level;
        if (nxt && !pwm) rise_cyc = cyc;
        pwm = nxt;
        if (gen_on) g_cnt = (g_cnt + 1 >= gen_per) ? 0 : g_cnt + 1;
    end

    initial forever begin
        @(negedge clk);
        if (bus_a.duty_valid && prev_dv) consec++;
        if (bus_a.duty_valid) begin
            val_total++;
            if (bus_a.duty < 8'd127 || bus_a.duty > 8'd129) bad_total++;
        end
        if (bus_a.overrun) ovr_total++;
        prev_dv = bus_a.duty_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_gen(input bit on, input bit level, input int per, input int hi);
        gen_on    = on;
        gen_level = level;
        gen_per   = per;
        gen_hi    = hi;
        gen_seq++;
    endtask

    task automatic wait_valid(input string tag, input int budget, output int vcyc);
        bit found = 1'b0;
        vcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus_a.duty_valid) begin
                found = 1'b1;
                vcyc  = cyc;
                break;
            end
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        int v0, v1, r0, w_val, w_bad, w_ovr;

        repeat (5) @(negedge clk);
        check("rst_duty", 32'(bus_a.duty), 32'd0);
        check("rst_valid", 32'(bus_a.duty_valid), 32'd0);
        check("rst_period", 32'(bus_a.period), 32'd0);
        check("rst_stuck", 32'(bus_a.stuck), 32'd0);
        check("rst_overrun", 32'(bus_a.overrun), 32'd0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_no_valid", 32'(val_total), 32'd0);

        // period 256, high 64: first rise only arms
        set_gen(1'b1, 1'b0, 256, 64);
        wait_valid("t1_found", 1000, v0);
        check("t1_first_arm", 32'(v0 - start_cyc), 32'd268);
        check("t1_latency", 32'(v0 - rise_cyc), 32'd12);
        check("t1_duty", 32'(bus_a.duty), 32'd64);
        check("t1_period", 32'(bus_a.period), 32'd256);
        check("t1_stuck", 32'(bus_a.stuck), 32'd0);
        wait_valid("t1_found2", 1000, v1);
        check("t1_interval", 32'(v1 - v0), 32'd256);
        check("t1_duty2", 32'(bus_a.duty), 32'd64);
        check("t4_al_duty", 32'(bus_b.duty), 32'd192);
        check("t4_al_period", 32'(bus_b.period), 32'd256);

        // period 1000 at 50%, 99.9% and 0.1%
        set_gen(1'b1, 1'b0, 1000, 500);
        repeat (3) wait_valid("t2a_found", 2500, v0);
        check("t2a_duty", 32'(bus_a.duty), 32'd128);
        check("t2a_period", 32'(bus_a.period), 32'd1000);
        set_gen(1'b1, 1'b0, 1000, 999);
        repeat (3) wait_valid("t2b_found", 2500, v0);
        check("t2b_duty", 32'(bus_a.duty), 32'd255);
        set_gen(1'b1, 1'b0, 1000, 1);
        repeat (3) wait_valid("t2c_found", 2500, v0);
        check("t2c_duty", 32'(bus_a.duty), 32'd0);
        check("t2c_period", 32'(bus_a.period), 32'd1000);

        // input held high from reset: both instances time out
        rst_n = 1'b0;
        set_gen(1'b0, 1'b1, 256, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_valid("t3_found", 5000, v0);
        check("t3_stuck", 32'(bus_a.stuck), 32'd1);
        check("t3_duty", 32'(bus_a.duty), 32'd255);
        check("t3_period", 32'(bus_a.period), 32'd0);
        check("t4_al_stuck", 32'(bus_b.stuck), 32'd1);
        check("t4_al_stuck_duty", 32'(bus_b.duty), 32'd0);
        wait_valid("t3_found2", 5000, v1);
        check("t3_interval", 32'(v1 - v0), 32'd4097);
        set_gen(1'b1, 1'b0, 256, 128);
        wait_valid("t3_resume_found", 1000, v0);
        check("t3_resume_stuck", 32'(bus_a.stuck), 32'd0);
        check("t3_resume_duty", 32'(bus_a.duty), 32'd128);
        check("t3_resume_period", 32'(bus_a.period), 32'd256);

        // period 6, shorter than the divider
        set_gen(1'b1, 1'b0, 6, 3);
        repeat (40) @(negedge clk);
        w_val = val_total;
        w_bad = bad_total;
        w_ovr = ovr_total;
        repeat (300) @(negedge clk);
        check("t5_valids", 32'(val_total - w_val > 10), 32'd1);
        check("t5_overruns", 32'(ovr_total - w_ovr > 10), 32'd1);
        check("t5_bad_duty", 32'(bad_total - w_bad), 32'd0);

        // reset during divider cycle t+5
        set_gen(1'b1, 1'b0, 256, 64);
        repeat (3) wait_valid("t6_pre_found", 1000, v0);
        r0 = rise_cyc;
        for (int i = 0; i < 400 && rise_cyc == r0; i++) @(negedge clk);
        check("t6_rise_seen", 32'(rise_cyc != r0), 32'd1);
        r0 = rise_cyc;
        for (int i = 0; i < 400 && cyc < r0 + 7; i++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t6_rst_duty", 32'(bus_a.duty), 32'd0);
        check("t6_rst_period", 32'(bus_a.period), 32'd0);
        for (int i = 0; i < 400 && cyc < r0 + 100; i++) @(negedge clk);
        rst_n = 1'b1;
        wait_valid("t6_found", 1000, v0);
        check("t6_valid_cycle", 32'(v0 - r0), 32'd524);
        check("t6_duty", 32'(bus_a.duty), 32'd64);
        check("t6_period", 32'(bus_a.period), 32'd256);

        check("no_back_to_back_valid", 32'(consec), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
